// File: rtl/cp0_exc_unit_pkg.sv
// cp0_exc_unit_pkg
//   Shared definitions for the coprocessor-0 / exception unit:
//   CP0 register numbers, SR/Cause field bit positions, ExcCode values
//   and the default exception entry address.
package cp0_exc_unit_pkg;

    // CP0 register numbers (mfc0/mtc0 rd field)
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // SR fields
    localparam int unsigned SR_IM_LO  = 10;
    localparam int unsigned SR_IM_HI  = 15;
    localparam int unsigned SR_EXL    = 1;
    localparam int unsigned SR_IE     = 0;

    // Cause fields
    localparam int unsigned CAUSE_BD      = 31;
    localparam int unsigned CAUSE_IP_LO   = 10;
    localparam int unsigned CAUSE_IP_HI   = 15;
    localparam int unsigned CAUSE_EXC_LO  = 2;
    localparam int unsigned CAUSE_EXC_HI  = 6;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Defaults
    localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] DEFAULT_PRID       = 32'h0000_2019;

endpackage

// File: rtl/cp0_exc_arbiter.sv
// cp0_exc_arbiter
//   Combinational decision of whether the MEM-stage instruction is replaced
//   by an interrupt or a synchronous exception, and which ExcCode to record.
// Ports:
//   reset      in   forces int_req low while the core is held in reset
//   hw_int     in   external interrupt lines (level)
//   sr_im      in   SR.IM interrupt mask
//   sr_ie      in   SR.IE global interrupt enable
//   sr_exl     in   SR.EXL, blocks everything while a handler runs
//   exc_valid  in   MEM instruction carries a synchronous exception
//   exc_code   in   ExcCode of that exception
//   int_req    out  take exception/interrupt this cycle
//   sel_code   out  ExcCode to latch into Cause
module cp0_exc_arbiter
    import cp0_exc_unit_pkg::*;
(
    input  logic       reset,
    input  logic [5:0] hw_int,
    input  logic [5:0] sr_im,
    input  logic       sr_ie,
    input  logic       sr_exl,
    input  logic       exc_valid,
    input  logic [4:0] exc_code,
    output logic       int_req,
    output logic [4:0] sel_code
);

    logic int_pend;
    logic exc_pend;

    always_comb begin
        int_pend = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
        exc_pend = exc_valid & ~sr_exl;
        int_req  = ~reset & (int_pend | exc_pend);
        // Interrupt takes priority over a synchronous exception.
        sel_code = int_pend ? EXC_INT : exc_code;
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit
//   MIPS coprocessor 0 and exception arbiter for the MEM stage. Holds SR,
//   Cause, EPC and PrID, serves mfc0/mtc0/eret and requests a pipeline flush
//   plus redirect to the handler when an exception or interrupt is taken.
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   we           mtc0 write enable
//   addr         CP0 register number for mfc0/mtc0
//   wdata        mtc0 data
//   pc           PC of the MEM-stage instruction
//   bd           MEM instruction sits in a branch delay slot
//   exc_valid    MEM instruction carries a synchronous exception
//   exc_code     ExcCode of that exception
//   hw_int       external interrupt lines, level-sensitive
//   eret         eret in MEM
//   rdata        mfc0 read data (combinational, pre-edge values)
//   epc_out      current EPC (eret target)
//   int_req      flush MEM/WB and redirect PC this cycle
//   handler_pc   exception entry address
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = DEFAULT_PRID,
    parameter logic [31:0] HANDLER_PC = DEFAULT_HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic [31:0] rdata,
    output logic [31:0] epc_out,
    output logic        int_req,
    output logic [31:0] handler_pc
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic [4:0]  sel_code;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    cp0_exc_arbiter u_arb (
        .reset     (reset),
        .hw_int    (hw_int),
        .sr_im     (sr_im),
        .sr_ie     (sr_ie),
        .sr_exl    (sr_exl),
        .exc_valid (exc_valid),
        .exc_code  (exc_code),
        .int_req   (int_req),
        .sel_code  (sel_code)
    );

    // Delay-slot instructions restart at the branch, one word earlier.
    always_comb begin
        epc_next = (bd ? (pc - 32'd4) : pc) & 32'hFFFF_FFFC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (int_req) begin
                // The MEM instruction is cancelled: its mtc0/eret are dropped.
                sr_exl    <= 1'b1;
                cause_bd  <= bd;
                cause_exc <= sel_code;
                epc       <= epc_next;
            end else begin
                if (eret) begin
                    sr_exl <= 1'b0;
                end
                if (we) begin
                    if (addr == CP0_SR) begin
                        sr_im  <= wdata[SR_IM_HI:SR_IM_LO];
                        sr_exl <= wdata[SR_EXL];
                        sr_ie  <= wdata[SR_IE];
                    end else if (addr == CP0_EPC) begin
                        epc <= wdata & 32'hFFFF_FFFC;
                    end
                end
            end
        end
    end

    always_comb begin
        sr_word = '0;
        sr_word[SR_IM_HI:SR_IM_LO] = sr_im;
        sr_word[SR_EXL]            = sr_exl;
        sr_word[SR_IE]             = sr_ie;

        cause_word = '0;
        cause_word[CAUSE_BD]                  = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;

        case (addr)
            CP0_SR:    rdata = sr_word;
            CP0_CAUSE: rdata = cause_word;
            CP0_EPC:   rdata = epc;
            CP0_PRID:  rdata = PRID_VALUE;
            default:   rdata = '0;
        endcase
    end

    assign epc_out    = epc;
    assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit
//   Directed self-checking bench for cp0_exc_unit with hand-computed
//   expected register values.
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        bd;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic        int_req;
    logic [31:0] handler_pc;

    int total = 0;
    int bad   = 0;

    cp0_exc_unit #(
        .PRID_VALUE (32'h0000_2019),
        .HANDLER_PC (32'h0000_4180)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .pc         (pc),
        .bd         (bd),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .hw_int     (hw_int),
        .eret       (eret),
        .rdata      (rdata),
        .epc_out    (epc_out),
        .int_req    (int_req),
        .handler_pc (handler_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; pc = '0; bd = 1'b0;
        exc_valid = 1'b0; exc_code = '0; hw_int = '0; eret = 1'b0;
        tick();
        hw_int = 6'b000001; exc_valid = 1'b1;
        #1;
        check("int_req_in_reset", {31'd0, int_req}, 32'd0);
        tick();
        reset = 1'b0; hw_int = '0; exc_valid = 1'b0;
        tick();
        rd("reset_sr", 5'd12, 32'h0000_0000);
        rd("reset_cause", 5'd13, 32'h0000_0000);
        rd("reset_epc", 5'd14, 32'h0000_0000);
        rd("prid", 5'd15, 32'h0000_2019);
        check("handler_pc", handler_pc, 32'h0000_4180);

        // 1: interrupt taken
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_after_mtc0", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; pc = 32'h0000_1000; bd = 1'b0;
        #1;
        check("int_req_irq", {31'd0, int_req}, 32'd1);
        tick();
        hw_int = '0;
        rd("irq_cause", 5'd13, 32'h0000_0400);
        rd("irq_sr", 5'd12, 32'h0000_0403);
        check("irq_epc", epc_out, 32'h0000_1000);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);

        // 2: synchronous exception in delay slot with SR=0
        mtc0(5'd12, 32'h0000_0000);
        exc_valid = 1'b1; exc_code = 5'd12; bd = 1'b1; pc = 32'h0000_3010;
        #1;
        check("int_req_exc", {31'd0, int_req}, 32'd1);
        tick();
        exc_valid = 1'b0; bd = 1'b0;
        check("exc_epc", epc_out, 32'h0000_300C);
        rd("exc_cause", 5'd13, 32'h8000_0030);
        rd("exc_sr", 5'd12, 32'h0000_0002);
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // 3: interrupt beats exception
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; exc_valid = 1'b1; exc_code = 5'd10; pc = 32'h0000_2000;
        #1;
        check("int_req_both", {31'd0, int_req}, 32'd1);
        tick();
        rd("both_cause", 5'd13, 32'h0000_0400);
        check("both_epc", epc_out, 32'h0000_2000);

        // 4: masked while EXL, eret re-enables pending interrupt
        #1;
        check("int_req_exl_masked", {31'd0, int_req}, 32'd0);
        tick();
        exc_valid = 1'b0;
        check("exl_epc_hold", epc_out, 32'h0000_2000);
        eret = 1'b1;
        #1;
        check("int_req_eret_cycle", {31'd0, int_req}, 32'd0);
        tick();
        eret = 1'b0;
        rd("post_eret_sr", 5'd12, 32'h0000_0401);
        check("int_req_after_eret", {31'd0, int_req}, 32'd1);
        hw_int = '0;
        #1;
        check("int_req_idle", {31'd0, int_req}, 32'd0);

        // 5: EPC write alignment, read-only/ignored registers
        we = 1'b1; addr = 5'd14; wdata = 32'h0000_3007;
        #1;
        check("epc_no_forward", rdata, 32'h0000_2000);
        tick();
        we = 1'b0;
        check("mtc0_epc", epc_out, 32'h0000_3004);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0000_0000);
        mtc0(5'd15, 32'h0000_0000);
        rd("prid_ro", 5'd15, 32'h0000_2019);
        rd("unmapped", 5'd3, 32'h0000_0000);

        // 6: mtc0 dropped under exception, reset mid-handler
        we = 1'b1; addr = 5'd12; wdata = 32'hFFFF_FFFF;
        exc_valid = 1'b1; exc_code = 5'd4; pc = 32'h0000_5000;
        #1;
        check("int_req_drop", {31'd0, int_req}, 32'd1);
        tick();
        we = 1'b0; exc_valid = 1'b0;
        rd("drop_sr", 5'd12, 32'h0000_0403);
        rd("drop_cause", 5'd13, 32'h0000_0010);
        check("drop_epc", epc_out, 32'h0000_5000);
        reset = 1'b1; hw_int = 6'b000001; exc_valid = 1'b1;
        #1;
        check("int_req_reset_mid", {31'd0, int_req}, 32'd0);
        tick();
        reset = 1'b0; exc_valid = 1'b0;
        rd("rst_sr", 5'd12, 32'h0000_0000);
        check("rst_epc", epc_out, 32'h0000_0000);
        check("int_req_masked_after_rst", {31'd0, int_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
MIPS coprocessor-0 and exception arbiter for the MEM stage of the 5-stage pipeline. It holds the SR, Cause, EPC and PrID registers, serves mfc0/mtc0/eret, and decides each cycle whether the instruction in MEM must be replaced by an exception or interrupt. Its int_req output drives the Interrupt flush input of the MEM/WB pipeline register and the PC redirect to the handler.

Parameters:
PRID_VALUE, 32'h0000_2019, read-only PrID contents
HANDLER_PC, 32'h0000_4180, exception entry address output on handler_pc

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
we  in  1  mtc0 write enable (MEM stage)
addr  in  5  CP0 register number for mfc0/mtc0
wdata  in  32  mtc0 data (rt value)
pc  in  32  PC of the instruction currently in MEM
bd  in  1  MEM instruction is in a branch delay slot
exc_valid  in  1  MEM instruction carries a synchronous exception
exc_code  in  5  ExcCode of that exception (4 AdEL, 5 AdES, 10 RI, 12 Ov)
hw_int  in  6  external interrupt lines, level-sensitive
eret  in  1  eret in MEM
rdata  out  32  mfc0 read data, combinational from addr
epc_out  out  32  current EPC, eret target
int_req  out  1  take exception/interrupt this cycle; flush MEM/WB, redirect PC
handler_pc  out  32  constant HANDLER_PC

Behaviour:
- Register fields: SR {IM[15:10], EXL[1], IE[0]}, other bits read 0. Cause {BD[31], IP[15:10], ExcCode[6:2]}, other bits read 0. EPC is 32 bits with [1:0] forced to 0. PrID = PRID_VALUE.
- Reset (clk edge with reset=1): SR=0, Cause=0, EPC=0. int_req=0 while reset=1, whatever the other inputs are.
- Cause.IP <= hw_int on every non-reset edge, unconditionally.
- int_pend = |(hw_int & SR.IM) & SR.IE & !SR.EXL.
- exc_pend = exc_valid & !SR.EXL.
- int_req = int_pend | exc_pend, combinational, same cycle.
- On an edge with int_req=1:
  - EXL <= 1.
  - BD <= bd.
  - EPC <= bd ? (pc-4) : pc, with [1:0] cleared.
  - ExcCode <= int_pend ? 0 : exc_code. Interrupt has priority over a synchronous exception.
- On an edge with eret=1 and int_req=0: EXL <= 0. eret with EXL=0 is a no-op.
- mtc0 (we=1, int_req=0):
  - addr 12 writes IM, EXL and IE only.
  - addr 14 writes EPC, with [1:0] cleared.
  - addr 13, 15 and any other address: the write is ignored.
- When int_req=1 the same-cycle mtc0 and eret are dropped. The instruction is being cancelled.
- rdata: addr 12/13/14/15 returns SR/Cause/EPC/PrID; any other address returns 0. Same-cycle writes are not forwarded; rdata reflects the pre-edge value.
- epc_out reflects EPC immediately after the edge that writes it.
- No exceptions nest while EXL=1. Interrupt and exception requests stay masked until eret.
- Reset mid-handler clears EXL and IE, so the CPU restarts with all interrupts masked.

Decomposition:
- Shared package holds:
  - CP0 register indices: SR=12, CAUSE=13, EPC=14, PRID=15.
  - Field bit positions: IM, EXL, IE, BD, IP, ExcCode.
  - ExcCode constants: INT, ADEL, ADES, RI, OV.
  - HANDLER_PC default.
- No sub-module. One optional combinational helper, cp0_exc_arbiter, computes int_pend, exc_pend, int_req and the selected ExcCode if the team prefers separation.

Test Plan:
1. Reset, then mtc0 addr12 wdata=32'h0000_0401, then hw_int=6'b000001 -> int_req=1 that cycle; next edge Cause=32'h0000_0400 (IP0, ExcCode 0), SR.EXL=1, EPC=pc.
2. exc_valid=1, exc_code=12, bd=1, pc=32'h0000_3010, SR=0 -> int_req=1 regardless of IE; EPC=32'h0000_300C, Cause=32'h8000_0030.
3. Same cycle: hw_int enabled and exc_valid=1, exc_code=10 -> ExcCode=0 (interrupt wins), int_req=1.
4. EXL=1 with hw_int and exc_valid asserted -> int_req=0; then eret -> EXL=0 next edge and a pending interrupt raises int_req the following cycle.
5. mtc0 addr14 wdata=32'h0000_3007 -> EPC=32'h0000_3004; mtc0 addr13 and addr15 -> Cause and PrID unchanged; mfc0 addr15 -> 32'h0000_2019; mfc0 addr3 -> 0.
6. mtc0 SR=32'hFFFF_FFFF asserted in the same cycle as an exception -> write dropped; then reset with EXL=1 -> SR=0, int_req=0 during reset.
